keypad_scanner: RTL

- Upstream input stage for the sample-processing FSM: scans a 4x4 matrix keypad and debounces key presses.
- Each confirmed press is encoded as a 4-bit `sample` code, with a one-cycle `sample_valid` strobe.
- The FSM's `sample` input is driven directly from this block's `sample` output.
- Rows are asynchronous pad inputs: synchronised internally, active-low with external pull-ups.

---
 rtl/keypad_scanner.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and one-cycle sample strobe.
// Latency: 2 cycles of row synchronisation, then detection at dwell end plus DEBOUNCE_CNT cycles to sample_valid.
// No backpressure: sample_valid is a fire-and-forget strobe, and sample holds until the next accepted press.
module keypad_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] sample,
  output logic       sample_valid,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_CNT);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2
  } state_t;

  // Registered state
  state_t        r_state;
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [DW-1:0] r_dwell;
  logic [BW-1:0] r_deb;
  logic [1:0]    r_col_idx;
  logic [3:0]    r_col;
  logic [1:0]    r_row_idx;
  logic [3:0]    r_sample;
  logic          r_sample_valid;
  logic          r_key_held;

  // Next-state values
  state_t        w_state_nxt;
  logic [DW-1:0] w_dwell_nxt;
  logic [BW-1:0] w_deb_nxt;
  logic [1:0]    w_col_idx_nxt;
  logic [3:0]    w_col_nxt;
  logic [1:0]    w_row_idx_nxt;
  logic [3:0]    w_sample_nxt;
  logic          w_sample_valid_nxt;
  logic          w_key_held_nxt;

  // Synchronised row view and derived decisions
  logic [3:0]    w_row_s;
  logic          w_any_low;
  logic [1:0]    w_low_idx;
  logic          w_key_up;

  assign w_row_s   = r_sync2;
  assign w_any_low = (w_row_s != 4'hF);
  assign w_key_up  = w_row_s[r_row_idx];

  // Lowest-index low row wins when several rows are down at once
  always_comb begin
    w_low_idx = 2'd0;
    if (!w_row_s[0])      w_low_idx = 2'd0;
    else if (!w_row_s[1]) w_low_idx = 2'd1;
    else if (!w_row_s[2]) w_low_idx = 2'd2;
    else if (!w_row_s[3]) w_low_idx = 2'd3;
  end

  // Scan / debounce / held-key state machine: next-state and output values
  always_comb begin
    w_state_nxt        = r_state;
    w_dwell_nxt        = r_dwell;
    w_deb_nxt          = r_deb;
    w_col_idx_nxt      = r_col_idx;
    w_row_idx_nxt      = r_row_idx;
    w_sample_nxt       = r_sample;
    w_sample_valid_nxt = 1'b0;
    w_key_held_nxt     = r_key_held;

    case (r_state)
      ST_SCAN: begin
        if (r_dwell == DWELL_LAST) begin
          w_dwell_nxt = '0;
          if (!w_any_low) begin
            w_col_idx_nxt = r_col_idx + 2'd1;
          end else begin
            // Column stays frozen while the candidate key is debounced
            w_row_idx_nxt = w_low_idx;
            w_deb_nxt     = '0;
            w_state_nxt   = ST_DEBOUNCE;
          end
        end else begin
          w_dwell_nxt = r_dwell + 1'b1;
        end
      end

      ST_DEBOUNCE: begin
        if (w_key_up) begin
          // Bounce: give up and move on rather than re-checking this column
          w_state_nxt   = ST_SCAN;
          w_dwell_nxt   = '0;
          w_col_idx_nxt = r_col_idx + 2'd1;
        end else if (r_deb == DEB_LAST) begin
          w_state_nxt        = ST_PRESSED;
          w_deb_nxt          = '0;
          w_sample_nxt       = {r_row_idx, r_col_idx};
          w_sample_valid_nxt = 1'b1;
          w_key_held_nxt     = 1'b1;
        end else begin
          w_deb_nxt = r_deb + 1'b1;
        end
      end

      ST_PRESSED: begin
        if (w_key_up) begin
          if (r_deb == DEB_LAST) begin
            w_state_nxt    = ST_SCAN;
            w_key_held_nxt = 1'b0;
            w_dwell_nxt    = '0;
            w_deb_nxt      = '0;
            w_col_idx_nxt  = r_col_idx + 2'd1;
          end else begin
            w_deb_nxt = r_deb + 1'b1;
          end
        end else begin
          // Any low glitch restarts the release qualification
          w_deb_nxt = '0;
        end
      end

      default: begin
        w_state_nxt = ST_SCAN;
      end
    endcase

    w_col_nxt = ~(4'b0001 << w_col_idx_nxt);
  end

  // State register, row synchroniser and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_SCAN;
      r_sync1        <= 4'hF;
      r_sync2        <= 4'hF;
      r_dwell        <= '0;
      r_deb          <= '0;
      r_col_idx      <= 2'd0;
      r_col          <= 4'b1110;
      r_row_idx      <= 2'd0;
      r_sample       <= 4'h0;
      r_sample_valid <= 1'b0;
      r_key_held     <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_sync1        <= row;
      r_sync2        <= r_sync1;
      r_dwell        <= w_dwell_nxt;
      r_deb          <= w_deb_nxt;
      r_col_idx      <= w_col_idx_nxt;
      r_col          <= w_col_nxt;
      r_row_idx      <= w_row_idx_nxt;
      r_sample       <= w_sample_nxt;
      r_sample_valid <= w_sample_valid_nxt;
      r_key_held     <= w_key_held_nxt;
    end
  end

  assign col          = r_col;
  assign sample       = r_sample;
  assign sample_valid = r_sample_valid;
  assign key_held     = r_key_held;

endmodule
